// File: rtl/dds_sample_sequencer_if.sv
// -----------------------------------------------------------------------------
// dds_sample_sequencer_if
// Purpose : Groups the handshake and data buses between the DDS sample
//           sequencer and its neighbours (SPI ADC front end, sine ROM and the
//           DAC/PWM loaders).
// Signals :
//   adc_start  1-cycle pulse, start an ADC conversion        (seq -> adc)
//   adc_valid  ADC result valid                               (adc -> seq)
//   adc_data   10-bit ADC result                              (adc -> seq)
//   rom_addr   10-bit sine ROM address (phase accumulator)    (seq -> rom)
//   rom_data   10-bit sine ROM word                           (rom -> seq)
//   dac_start  1-cycle pulse, load dac_data into DAC and PWM  (seq -> dac)
//   dac_data   10-bit sample for the DAC/PWM loaders          (seq -> dac)
// Modports: master = sequencer side, slave = peripheral side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface dds_sample_sequencer_if;
  logic       adc_start;
  logic       adc_valid;
  logic [9:0] adc_data;
  logic [9:0] rom_addr;
  logic [9:0] rom_data;
  logic       dac_start;
  logic [9:0] dac_data;

  modport master (
    output adc_start, rom_addr, dac_start, dac_data,
    input  adc_valid, adc_data, rom_data
  );

  modport slave (
    input  adc_start, rom_addr, dac_start, dac_data,
    output adc_valid, adc_data, rom_data
  );
endinterface

// File: rtl/dds_sample_sequencer.sv
// -----------------------------------------------------------------------------
// dds_sample_sequencer
// Purpose : Per-sample scheduler for the DDS voice path. Every DIV clocks a
//           tick starts one sample period: request an ADC conversion, take the
//           result as the phase increment, advance the phase accumulator
//           (which addresses the sine ROM), wait for the ROM and hand the ROM
//           word to the DAC/PWM loaders.
// Parameters:
//   DIV          sysclk cycles per sample tick
//   ROM_LAT      cycles from rom_addr update to valid rom_data (1..3)
//   ADC_TIMEOUT  max cycles spent waiting for adc_valid
//   FREQ_INIT    reset value of the phase increment
// Ports:
//   i_sysclk       system clock
//   i_reset        synchronous active-high reset
//   i_enable       1 = run tick divider, 0 = divider held at 0 (no new ticks)
//   io_bus         master side of dds_sample_sequencer_if (ADC/ROM/DAC)
//   o_freq         current phase increment
//   o_busy         1 whenever a sample period is in progress
//   o_adc_tmo      1-cycle pulse when the ADC wait timed out
//   o_overrun_cnt  ticks dropped because a sample was still running (sat. 255)
// Build option:
//   FREQ_SMOOTH_EN  when defined, an ADC capture moves freq a quarter of the
//                   way towards adc_data instead of replacing it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dds_sample_sequencer #(
  parameter int         DIV         = 5000,
  parameter int         ROM_LAT     = 1,
  parameter int         ADC_TIMEOUT = 1023,
  parameter logic [9:0] FREQ_INIT   = 10'd127
) (
  input  logic                          i_sysclk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  dds_sample_sequencer_if.master        io_bus,
  output logic [9:0]                    o_freq,
  output logic                          o_busy,
  output logic                          o_adc_tmo,
  output logic [7:0]                    o_overrun_cnt
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WAIT_W = $clog2(ADC_TIMEOUT + 1);
  localparam int LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADC_TIMEOUT);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADC_REQ,
    S_ADC_WAIT,
    S_ACCUM,
    S_ROM_WAIT,
    S_DAC_REQ
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [9:0]         r_phase;
  logic [9:0]         r_freq;
  logic [9:0]         r_dac_data;
  logic [7:0]         r_overrun_cnt;

  logic               w_tick;
  logic               w_adc_start;
  logic               w_dac_start;
  logic               w_adc_tmo;
  logic               w_capture;
  logic               w_accum;
  logic [9:0]         w_freq_capture;

  assign w_tick = (r_div_cnt == DIV_LAST) & i_enable;

  // Tick divider: held at 0 while disabled so re-enabling gives a full period.
  always_ff @(posedge i_sysclk) begin
    if (i_reset || !i_enable) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

`ifdef FREQ_SMOOTH_EN
  // First-order smoothing: freq += (adc_data - freq) >>> 2 on an 11-bit
  // signed difference, result wrapped to 10 bits.
  logic signed [10:0] w_freq_diff;
  logic signed [10:0] w_freq_step;
  assign w_freq_diff    = $signed({1'b0, io_bus.adc_data}) - $signed({1'b0, r_freq});
  assign w_freq_step    = w_freq_diff >>> 2;
  assign w_freq_capture = r_freq + w_freq_step[9:0];
`else
  assign w_freq_capture = io_bus.adc_data;
`endif

  // Next-state and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    w_adc_start  = 1'b0;
    w_dac_start  = 1'b0;
    w_adc_tmo    = 1'b0;
    w_capture    = 1'b0;
    w_accum      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) w_state_next = S_ADC_REQ;
      end
      S_ADC_REQ: begin
        w_adc_start  = 1'b1;
        w_state_next = S_ADC_WAIT;
      end
      S_ADC_WAIT: begin
        // A result arriving on the timeout cycle still counts as valid.
        if (io_bus.adc_valid) begin
          w_capture    = 1'b1;
          w_state_next = S_ACCUM;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_adc_tmo    = 1'b1;
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_accum      = 1'b1;
        w_state_next = S_ROM_WAIT;
      end
      S_ROM_WAIT: begin
        if (r_lat_cnt == '0) w_state_next = S_DAC_REQ;
      end
      S_DAC_REQ: begin
        w_dac_start  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_lat_cnt     <= '0;
      r_phase       <= '0;
      r_freq        <= FREQ_INIT;
      r_dac_data    <= '0;
      r_overrun_cnt <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_ADC_REQ) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_ADC_WAIT) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      if (r_state == S_ACCUM) begin
        r_lat_cnt <= LAT_LOAD;
      end else if (r_state == S_ROM_WAIT && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end

      if (w_capture)   r_freq     <= w_freq_capture;
      // Phase wraps silently modulo 1024.
      if (w_accum)     r_phase    <= r_phase + r_freq;
      if (w_dac_start) r_dac_data <= io_bus.rom_data;

      // A tick that lands while a sample is running is dropped and counted.
      if (w_tick && r_state != S_IDLE && r_overrun_cnt != 8'hFF) begin
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end
    end
  end

  assign io_bus.adc_start = w_adc_start;
  assign io_bus.rom_addr  = r_phase;
  assign io_bus.dac_start = w_dac_start;
  // The ROM word is forwarded during the load cycle so dac_data is already
  // valid alongside dac_start; the register holds it afterwards.
  assign io_bus.dac_data  = (r_state == S_DAC_REQ) ? io_bus.rom_data : r_dac_data;

  assign o_freq        = r_freq;
  assign o_busy        = (r_state != S_IDLE);
  assign o_adc_tmo     = w_adc_tmo;
  assign o_overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_dds_sample_sequencer.sv
`timescale 1ns/1ps
module tb_dds_sample_sequencer;
  localparam int DIV  = 50;
  localparam int LAT  = 1;
  localparam int TMO  = 20;
  localparam int TMO2 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, en, rst2, en2;
  logic [9:0] freq, freq2;
  logic       busy, busy2, tmo, tmo2;
  logic [7:0] ovr, ovr2;

  dds_sample_sequencer_if bus ();
  dds_sample_sequencer_if bus2 ();

  dds_sample_sequencer #(.DIV(DIV), .ROM_LAT(LAT), .ADC_TIMEOUT(TMO), .FREQ_INIT(10'd127)) dut (
    .i_sysclk(clk), .i_reset(rst), .i_enable(en), .io_bus(bus),
    .o_freq(freq), .o_busy(busy), .o_adc_tmo(tmo), .o_overrun_cnt(ovr)
  );

  dds_sample_sequencer #(.DIV(DIV), .ROM_LAT(LAT), .ADC_TIMEOUT(TMO2), .FREQ_INIT(10'd127)) dut_ovr (
    .i_sysclk(clk), .i_reset(rst2), .i_enable(en2), .io_bus(bus2),
    .o_freq(freq2), .o_busy(busy2), .o_adc_tmo(tmo2), .o_overrun_cnt(ovr2)
  );

  // Sine ROM stand-in: arbitrary fixed table, one cycle of read latency.
  function automatic logic [9:0] rom_f(input logic [9:0] a);
    int v;
    v = (int'(a) * 37 + 5) % 1024;
    return 10'(v);
  endfunction

  always @(posedge clk) begin
    bus.rom_data  <= rom_f(bus.rom_addr);
    bus2.rom_data <= rom_f(bus2.rom_addr);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: phase and increment per the sample rules.
  logic [9:0] m_phase;
  logic [9:0] m_freq;
  int         prev_start;

  function automatic logic [9:0] model_capture(input int f, input int d);
    int diff;
    int q;
    diff = d - f;
`ifdef FREQ_SMOOTH_EN
    q = (diff >= 0) ? diff / 4 : -((-diff + 3) / 4);
    return 10'((f + q) % 1024);
`else
    q = diff;
    return 10'(f + q);
`endif
  endfunction

  // One full sample period. dly = cycle offset of adc_valid after adc_start
  // (1..TMO+1), anything else = never answer (timeout path).
  task automatic run_sample(input int dly, input logic [9:0] data, input bit drop_en);
    int n;
    int k;
    k = 0;
    while (!bus.adc_start && k < 200) begin @(negedge clk); k++; end
    if (!bus.adc_start) begin
      check("adc_start_seen", 0, 1);
      return;
    end
    n = cyc;
    if (prev_start >= 0) check("tick_period", n - prev_start, DIV);
    prev_start = n;
    if (drop_en) en = 1'b0;
    @(negedge clk);
    check("adc_start_width", bus.adc_start, 0);
    check("busy_in_sample", busy, 1);
    if (dly >= 1 && dly <= TMO + 1) begin
      repeat (dly - 1) @(negedge clk);
      bus.adc_valid = 1'b1;
      bus.adc_data  = data;
      #1;
      check("no_tmo_on_valid", tmo, 0);
      m_freq = model_capture(int'(m_freq), int'(data));
    end else begin
      repeat (TMO - 1) @(negedge clk);
      check("adc_tmo_early", tmo, 0);
      @(negedge clk);
      check("adc_tmo_pulse", tmo, 1);
    end
    m_phase = m_phase + m_freq;
    @(negedge clk);
    bus.adc_valid = 1'b0;
    bus.adc_data  = 10'($urandom);
    check("freq", freq, m_freq);
    check("adc_tmo_width", tmo, 0);
    @(negedge clk);
    check("rom_addr", bus.rom_addr, m_phase);
    check("dac_start_early", bus.dac_start, 0);
    @(negedge clk);
    check("dac_start", bus.dac_start, 1);
    check("dac_data", bus.dac_data, rom_f(m_phase));
    @(negedge clk);
    check("dac_start_width", bus.dac_start, 0);
    check("dac_data_hold", bus.dac_data, rom_f(m_phase));
    check("busy_done", busy, 0);
    check("overrun_none", ovr, 0);
    $display("[TB] sample t=%0d dly=%0d data=%0d freq=%0d rom_addr=%0d dac_data=%0d",
             n, dly, data, freq, bus.rom_addr, bus.dac_data);
  endtask

  initial begin
    int k;
    int d;
    rst = 1'b1; en = 1'b1; rst2 = 1'b1; en2 = 1'b1;
    bus.adc_valid = 1'b0;  bus.adc_data = '0;
    bus2.adc_valid = 1'b0; bus2.adc_data = '0;
    m_phase = '0; m_freq = 10'd127; prev_start = -1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_adc_start", bus.adc_start, 0);
    check("rst_rom_addr",  bus.rom_addr, 0);
    check("rst_dac_start", bus.dac_start, 0);
    check("rst_dac_data",  bus.dac_data, 0);
    check("rst_freq",      freq, 127);
    check("rst_busy",      busy, 0);
    check("rst_tmo",       tmo, 0);
    check("rst_ovr",       ovr, 0);
    check("rst_ovr2",      ovr2, 0);
    rst = 1'b0;
    prev_start = cyc;

    // Timeout with reset increment, then a steady increment of 3
    run_sample(0, 10'd0, 1'b0);
    repeat (3) run_sample(5, 10'd3, 1'b0);

    // Phase wrap: land on 1020, then add 10
    run_sample(5, 10'(1020 - int'(m_phase)), 1'b0);
`ifndef FREQ_SMOOTH_EN
    check("phase_1020", bus.rom_addr, 1020);
`endif
    run_sample(5, 10'd10, 1'b0);
`ifndef FREQ_SMOOTH_EN
    check("phase_wrap", bus.rom_addr, 6);
`endif

    // adc_valid on the timeout cycle wins
    run_sample(TMO + 1, 10'd77, 1'b0);

    // adc_valid while idle is ignored
    bus.adc_valid = 1'b1; bus.adc_data = 10'd999;
    @(negedge clk);
    bus.adc_valid = 1'b0;
    @(negedge clk);
    check("stray_valid_ignored", freq, m_freq);
    $display("[TB] stray valid freq=%0d", freq);

    // Randomized samples
    for (int i = 0; i < 10; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TMO + 1));
      run_sample(d, 10'($urandom_range(0, 1023)), 1'b0);
    end

    // enable dropped mid-sample: sample completes, no further ticks
    run_sample(4, 10'd200, 1'b1);
    k = 0;
    repeat (150) begin @(negedge clk); if (bus.adc_start) k++; end
    check("no_tick_disabled", k, 0);
    $display("[TB] disabled window adc_start count=%0d", k);
    en = 1'b1;
    prev_start = cyc;
    run_sample(2, 10'd5, 1'b0);

    // Reset in the middle of ADC_WAIT
    k = 0;
    while (!bus.adc_start && k < 200) begin @(negedge clk); k++; end
    check("adc_start_before_reset", bus.adc_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",      busy, 0);
    check("midrst_freq",      freq, 127);
    check("midrst_rom_addr",  bus.rom_addr, 0);
    check("midrst_dac_start", bus.dac_start, 0);
    check("midrst_dac_data",  bus.dac_data, 0);
    check("midrst_tmo",       tmo, 0);
    rst = 1'b0;
    prev_start = cyc;
    m_phase = '0; m_freq = 10'd127;
    k = 0;
    repeat (10) begin
      if (bus.dac_start || bus.adc_start || tmo) k++;
      @(negedge clk);
    end
    check("no_pulse_after_reset", k, 0);
    $display("[TB] mid-sample reset busy=%0d freq=%0d", busy, freq);
    run_sample(3, 10'd321, 1'b0);

    // Overrun counting on the long-timeout instance
    rst2 = 1'b0;
    k = 0;
    while (!bus2.adc_start && k < 200) begin @(negedge clk); k++; end
    check("ovr_adc_start_seen", bus2.adc_start, 1);
    repeat (60) @(negedge clk);
    bus2.adc_valid = 1'b1; bus2.adc_data = 10'd9;
    @(negedge clk);
    bus2.adc_valid = 1'b0;
    k = 0;
    while (!bus2.dac_start && k < 20) begin @(negedge clk); k++; end
    check("ovr_dac_seen", bus2.dac_start, 1);
    check("overrun_one", ovr2, 1);
    $display("[TB] overrun after slow sample=%0d", ovr2);
    @(negedge clk);
    k = 0;
    while (!bus2.dac_start && k < 300) begin @(negedge clk); k++; end
    check("ovr_dac2_seen", bus2.dac_start, 1);
    check("overrun_three", ovr2, 3);
    $display("[TB] overrun after timeout sample=%0d", ovr2);
    repeat (24000) @(negedge clk);
    check("overrun_saturated", ovr2, 255);
    check("overrun_main_untouched", ovr, 0);
    $display("[TB] overrun after long run=%0d", ovr2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
